// File: rtl/road_fighter_pkg.sv
// Shared types and widths for the car speed controller and its frame timers.
package road_fighter_pkg;
  localparam int SPEED_W     = 5;
  localparam int DIST_W      = 16;
  localparam int FRAME_CNT_W = 4;
  localparam int CRASH_CNT_W = 7;

  typedef enum logic [1:0] {IDLE_ST, RUN_ST, CRASH_ST, OVER_ST} spd_state_t;
  typedef enum logic [1:0] {M_ACCEL, M_BRAKE, M_COAST} drive_mode_t;

  // Odometer add that pins at all-ones instead of wrapping.
  function automatic logic [DIST_W-1:0] dist_sat_add(input logic [DIST_W-1:0] d,
                                                     input logic [SPEED_W-1:0] s);
    logic [DIST_W:0] sum;
    sum = {1'b0, d} + (DIST_W+1)'(s);
    return sum[DIST_W] ? {DIST_W{1'b1}} : sum[DIST_W-1:0];
  endfunction
endpackage

// File: rtl/frame_step_counter.sv
// Counts frame ticks against a run-time limit; step fires on the tick that reaches it.
module frame_step_counter
  import road_fighter_pkg::*;
#(
  parameter int CNT_W = FRAME_CNT_W
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             clear,
  input  logic             tick,
  input  logic             restart,
  input  logic [CNT_W-1:0] limit,
  output logic             step
);
  logic [CNT_W-1:0] cnt, cnt_nxt;

  // restart makes the current tick the first one of a fresh run
  assign cnt_nxt = restart ? CNT_W'(1) : cnt + CNT_W'(1);
  assign step    = tick & (cnt_nxt == limit);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)    cnt <= '0;
    else if (clear) cnt <= '0;
    else if (tick)  cnt <= step ? '0 : cnt_nxt;
  end
endmodule

// File: rtl/car_speed_ctrl.sv
// Turns accel/brake keys into a frame-quantised speed, with crash stall, game-over and odometer.
module car_speed_ctrl
  import road_fighter_pkg::*;
#(
  parameter int MAX_SPEED    = 31,
  parameter int ACCEL_FRAMES = 4,
  parameter int BRAKE_FRAMES = 1,
  parameter int COAST_FRAMES = 8,
  parameter int CRASH_FRAMES = 60
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               accelKey,
  input  logic               brakeKey,
  input  logic               collision,
  input  logic               gameOver,
  output logic [SPEED_W-1:0] speed,
  output logic               crashActive,
  output logic [DIST_W-1:0]  distance
);
  if (MAX_SPEED < 1 || MAX_SPEED > (1 << SPEED_W) - 1) begin : g_bad_max
    $error("MAX_SPEED out of range for speed bus");
  end
  if (ACCEL_FRAMES < 1 || ACCEL_FRAMES > (1 << FRAME_CNT_W) - 1 ||
      BRAKE_FRAMES < 1 || BRAKE_FRAMES > (1 << FRAME_CNT_W) - 1 ||
      COAST_FRAMES < 1 || COAST_FRAMES > (1 << FRAME_CNT_W) - 1) begin : g_bad_ramp
    $error("ramp frame counts exceed frame counter width");
  end
  if (CRASH_FRAMES < 1 || CRASH_FRAMES > (1 << CRASH_CNT_W) - 1) begin : g_bad_crash
    $error("CRASH_FRAMES exceeds crash counter width");
  end

  localparam logic [SPEED_W-1:0]     SPD_MAX = SPEED_W'(MAX_SPEED);
  localparam logic [FRAME_CNT_W-1:0] LIM_ACC = FRAME_CNT_W'(ACCEL_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] LIM_BRK = FRAME_CNT_W'(BRAKE_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] LIM_CST = FRAME_CNT_W'(COAST_FRAMES);
  localparam logic [CRASH_CNT_W-1:0] LIM_CRS = CRASH_CNT_W'(CRASH_FRAMES);

  spd_state_t               state, state_n;
  drive_mode_t              mode, prev_mode, mode_n;
  logic [SPEED_W-1:0]       speed_n;
  logic                     crash_n;
  logic [DIST_W-1:0]        dist_n;
  logic [FRAME_CNT_W-1:0]   ramp_limit;
  logic                     ramp_tick, ramp_step, crash_tick, crash_done;

  assign mode = brakeKey ? M_BRAKE : (accelKey ? M_ACCEL : M_COAST);

  always_comb begin
    ramp_limit = LIM_CST;
    case (mode)
      M_ACCEL: ramp_limit = LIM_ACC;
      M_BRAKE: ramp_limit = LIM_BRK;
      default: ramp_limit = LIM_CST;
    endcase
  end

  // A frame that collides or ends the game never advances the ramp.
  assign ramp_tick  = (state == RUN_ST) & startOfFrame & ~gameOver & ~collision;
  assign crash_tick = (state == CRASH_ST) & startOfFrame & ~gameOver;

  frame_step_counter #(.CNT_W(FRAME_CNT_W)) u_ramp (
    .clk     (clk),
    .resetN  (resetN),
    .clear   (state != RUN_ST),
    .tick    (ramp_tick),
    .restart (mode != prev_mode),
    .limit   (ramp_limit),
    .step    (ramp_step)
  );

  // Counting up to the stall length is equivalent to counting the stall down.
  frame_step_counter #(.CNT_W(CRASH_CNT_W)) u_crash (
    .clk     (clk),
    .resetN  (resetN),
    .clear   (state != CRASH_ST),
    .tick    (crash_tick),
    .restart (1'b0),
    .limit   (LIM_CRS),
    .step    (crash_done)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= IDLE_ST;
      prev_mode   <= M_COAST;
      speed       <= '0;
      crashActive <= 1'b0;
      distance    <= '0;
    end else begin
      state       <= state_n;
      prev_mode   <= mode_n;
      speed       <= speed_n;
      crashActive <= crash_n;
      distance    <= dist_n;
    end
  end

  always_comb begin
    state_n = state;
    mode_n  = prev_mode;
    speed_n = speed;
    crash_n = crashActive;
    dist_n  = distance;
    if (gameOver) begin
      state_n = OVER_ST;
      speed_n = '0;
      crash_n = 1'b0;
    end else begin
      case (state)
        IDLE_ST: begin
          speed_n = '0;
          if (startOfFrame && accelKey) state_n = RUN_ST;
        end
        RUN_ST: begin
          if (collision) begin
            state_n = CRASH_ST;
            speed_n = '0;
            crash_n = 1'b1;
          end else if (startOfFrame) begin
            mode_n = mode;
            dist_n = dist_sat_add(distance, speed);
            if (ramp_step) begin
              if (mode == M_ACCEL) begin
                if (speed < SPD_MAX) speed_n = speed + SPEED_W'(1);
              end else if (speed != '0) begin
                speed_n = speed - SPEED_W'(1);
              end
            end
          end
        end
        CRASH_ST: begin
          if (crash_done) begin
            state_n = RUN_ST;
            crash_n = 1'b0;
            speed_n = '0;
          end
        end
        OVER_ST: begin
          state_n = IDLE_ST;
          dist_n  = '0;
        end
        default: state_n = IDLE_ST;
      endcase
    end
  end
endmodule

// File: tb/tb_car_speed_ctrl.sv
// Directed scenarios plus a random run, checked every cycle against a frame-level model.
module tb_car_speed_ctrl;
  logic        clk = 1'b0, resetN = 1'b0;
  logic        sof = 1'b0, acc = 1'b0, brk = 1'b0, col = 1'b0, go = 1'b0;
  logic [4:0]  speed;
  logic        crashActive;
  logic [15:0] distance;
  int          checks = 0, errors = 0;

  typedef enum {S_IDLE, S_RUN, S_CRASH, S_OVER} mst_t;
  mst_t m_st;
  int   m_spd, m_dist, m_held, m_left, m_last;
  bit   m_crash;

  car_speed_ctrl dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (sof),
    .accelKey     (acc),
    .brakeKey     (brk),
    .collision    (col),
    .gameOver     (go),
    .speed        (speed),
    .crashActive  (crashActive),
    .distance     (distance)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int need(input int md);
    return (md == 0) ? 4 : (md == 1) ? 1 : 8;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_spd = 0; m_dist = 0; m_crash = 0; m_held = 0; m_left = 0; m_last = 2;
  endtask

  // mode codes: 0 accel, 1 brake, 2 coast
  task automatic model_clk();
    int md;
    if (go) begin
      m_st = S_OVER; m_spd = 0; m_crash = 0;
    end else begin
      case (m_st)
        S_IDLE: begin
          m_spd = 0;
          if (sof && acc) begin m_st = S_RUN; m_held = 0; end
        end
        S_RUN: begin
          if (col) begin
            m_st = S_CRASH; m_spd = 0; m_crash = 1; m_left = 60;
          end else if (sof) begin
            md     = brk ? 1 : (acc ? 0 : 2);
            m_dist = (m_dist + m_spd > 65535) ? 65535 : m_dist + m_spd;
            m_held = (md == m_last) ? m_held + 1 : 1;
            m_last = md;
            if (m_held == need(md)) begin
              m_held = 0;
              if (md == 0) m_spd = (m_spd < 31) ? m_spd + 1 : 31;
              else         m_spd = (m_spd > 0) ? m_spd - 1 : 0;
            end
          end
        end
        S_CRASH: begin
          if (sof) begin
            m_left--;
            if (m_left == 0) begin m_st = S_RUN; m_crash = 0; m_held = 0; end
          end
        end
        default: begin m_st = S_IDLE; m_dist = 0; end
      endcase
    end
  endtask

  task automatic cyc(input bit s, input bit a, input bit b, input bit c, input bit g);
    sof = s; acc = a; brk = b; col = c; go = g;
    @(posedge clk);
    model_clk();
    @(negedge clk);
    chk("speed", speed, m_spd);
    chk("crashActive", crashActive, m_crash);
    chk("distance", distance, m_dist);
  endtask

  task automatic frames(input int n, input bit a, input bit b);
    repeat (n) begin
      cyc(1, a, b, 0, 0);
      cyc(0, a, b, 0, 0);
    end
  endtask

  initial begin
    int d0, go_left;
    bit s, a, b, c, g;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_speed", speed, 0);
    chk("rst_crash", crashActive, 0);
    chk("rst_dist", distance, 0);
    resetN = 1'b1;
    cyc(0, 0, 0, 0, 0);

    // accelerate from idle to saturation
    frames(1, 1, 0);
    chk("t1_enter_run", speed, 0);
    frames(4, 1, 0);
    chk("t1_speed1", speed, 1);
    frames(120, 1, 0);
    chk("t1_speed31", speed, 31);
    frames(8, 1, 0);
    chk("t1_sat31", speed, 31);

    // brake wins over accel, then coast
    frames(21, 0, 1);
    chk("t2_speed10", speed, 10);
    frames(3, 1, 1);
    chk("t2_brake_wins", speed, 7);
    frames(7, 0, 0);
    chk("t2_coast7", speed, 7);
    frames(1, 0, 0);
    chk("t2_coast6", speed, 6);

    // collision on a frame pulse, stall, ignored second collision
    frames(56, 1, 0);
    chk("t3_speed20", speed, 20);
    d0 = m_dist;
    cyc(1, 1, 0, 1, 0);
    chk("t3_crash_spd", speed, 0);
    chk("t3_crash_on", crashActive, 1);
    chk("t3_dist_held", distance, d0);
    cyc(0, 0, 0, 0, 0);
    frames(10, 1, 0);
    cyc(0, 0, 0, 1, 0);
    frames(49, 1, 0);
    chk("t3_stall59", crashActive, 1);
    chk("t3_dist_stall", distance, d0);
    frames(1, 1, 0);
    chk("t3_stall_end", crashActive, 0);
    frames(4, 1, 0);
    chk("t3_run_again", speed, 1);

    // game over during a crash stall
    cyc(0, 0, 0, 1, 0);
    frames(3, 0, 0);
    d0 = m_dist;
    cyc(0, 0, 0, 0, 1);
    chk("t5_over_spd", speed, 0);
    chk("t5_over_crash", crashActive, 0);
    repeat (3) cyc(1, 1, 0, 0, 1);
    chk("t5_dist_frozen", distance, d0);
    cyc(0, 0, 0, 0, 0);
    chk("t5_dist_clear", distance, 0);
    frames(2, 0, 0);
    chk("t5_idle", speed, 0);

    // odometer saturation
    frames(1, 1, 0);
    for (int i = 0; i < 4000 && m_dist < 32'hFFF0; i++) frames(1, 1, 0);
    chk("t4_speed31", speed, 31);
    frames(1, 1, 0);
    chk("t4_dist_sat", distance, 32'hFFFF);
    frames(2, 1, 0);
    chk("t4_dist_stays", distance, 32'hFFFF);

    // asynchronous reset mid-run
    frames(16, 0, 1);
    chk("t6_speed15", speed, 15);
    #2 resetN = 1'b0;
    #1;
    chk("t6_async_spd", speed, 0);
    chk("t6_async_crash", crashActive, 0);
    chk("t6_async_dist", distance, 0);
    model_reset();
    @(negedge clk);
    resetN = 1'b1;
    frames(1, 0, 0);
    frames(1, 1, 0);
    frames(3, 1, 0);
    chk("t6_idle_restart", speed, 0);
    frames(1, 1, 0);
    chk("t6_run_speed1", speed, 1);

    // random traffic against the model
    go_left = 0;
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 9) < 7);
      b = ($urandom_range(0, 9) < 2);
      c = ($urandom_range(0, 79) == 0);
      if (go_left == 0 && $urandom_range(0, 399) == 0) go_left = $urandom_range(1, 4);
      g = (go_left != 0);
      if (go_left != 0) go_left--;
      cyc(s, a, b, c, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
